// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared FFT frame geometry, peak-record type and the
//               absolute-value helper used by the magnitude pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

  localparam int FFT_N  = 1024;
  localparam int FFT_AW = 10;
  localparam int FFT_DW = 32;

  // Running-maximum record: bin index together with its magnitude
  typedef struct packed {
    logic [FFT_AW-1:0] bin;
    logic [FFT_DW-1:0] mag;
  } peak_t;

  // Unsigned absolute value; the most negative input maps to 2^(DW-1),
  // which still fits in DW unsigned bits.
  function automatic logic [FFT_DW-1:0] abs_u(input logic signed [FFT_DW-1:0] v);
    abs_u = v[FFT_DW-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_mag_approx.sv
`default_nettype none
// ============================================================================
// Module      : fft_mag_approx
// Description : Three-stage alpha-max-plus-beta-min magnitude approximation,
//               mag = max + min/4 + min/8, one sample per cycle, bubbles
//               carried through with the valid bit.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_mag_approx
  import fft_pkg::*;
(
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     in_avail_i,
  input  logic [FFT_AW-1:0]        in_cnt_i,
  input  logic signed [FFT_DW-1:0] in_re_i,
  input  logic signed [FFT_DW-1:0] in_im_i,
  output logic                     mag_valid_o,
  output logic [FFT_AW-1:0]        mag_addr_o,
  output logic [FFT_DW-1:0]        mag_data_o
);

  logic              s1_vld_q,  s1_vld_d;
  logic [FFT_AW-1:0] s1_addr_q, s1_addr_d;
  logic [FFT_DW-1:0] s1_re_q,   s1_re_d;
  logic [FFT_DW-1:0] s1_im_q,   s1_im_d;

  logic              s2_vld_q,  s2_vld_d;
  logic [FFT_AW-1:0] s2_addr_q, s2_addr_d;
  logic [FFT_DW-1:0] s2_max_q,  s2_max_d;
  logic [FFT_DW-1:0] s2_min_q,  s2_min_d;

  logic              s3_vld_q,  s3_vld_d;
  logic [FFT_AW-1:0] s3_addr_q, s3_addr_d;
  logic [FFT_DW-1:0] s3_mag_q,  s3_mag_d;

  // Next-state of all stages: abs, then max/min ordering, then scaled sum
  always_comb begin
    s1_vld_d  = in_avail_i;
    s1_addr_d = in_cnt_i;
    s1_re_d   = abs_u(in_re_i);
    s1_im_d   = abs_u(in_im_i);

    s2_vld_d  = s1_vld_q;
    s2_addr_d = s1_addr_q;
    if (s1_re_q >= s1_im_q) begin
      s2_max_d = s1_re_q;
      s2_min_d = s1_im_q;
    end else begin
      s2_max_d = s1_im_q;
      s2_min_d = s1_re_q;
    end

    // max <= 2^31 so max + 3/8*max stays below 2^32
    s3_vld_d  = s2_vld_q;
    s3_addr_d = s2_addr_q;
    s3_mag_d  = s2_max_q + (s2_min_q >> 2) + (s2_min_q >> 3);
  end

  // Pipeline registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      s1_re_q   <= '0;
      s1_im_q   <= '0;
      s2_vld_q  <= 1'b0;
      s2_addr_q <= '0;
      s2_max_q  <= '0;
      s2_min_q  <= '0;
      s3_vld_q  <= 1'b0;
      s3_addr_q <= '0;
      s3_mag_q  <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_addr_q <= s1_addr_d;
      s1_re_q   <= s1_re_d;
      s1_im_q   <= s1_im_d;
      s2_vld_q  <= s2_vld_d;
      s2_addr_q <= s2_addr_d;
      s2_max_q  <= s2_max_d;
      s2_min_q  <= s2_min_d;
      s3_vld_q  <= s3_vld_d;
      s3_addr_q <= s3_addr_d;
      s3_mag_q  <= s3_mag_d;
    end
  end

  assign mag_valid_o = s3_vld_q;
  assign mag_addr_o  = s3_addr_q;
  assign mag_data_o  = s3_mag_q;

endmodule
`default_nettype wire

// File: rtl/fft_peak_detect.sv
`default_nettype none
// ============================================================================
// Module      : fft_peak_detect
// Description : Streams approximate FFT bin magnitudes and tracks the largest
//               one over a frame (bins 0..1023), reporting it with a done
//               pulse, a wrapping frame counter and a sticky sequence error.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_peak_detect
  import fft_pkg::*;
#(
  parameter int unsigned SEARCH_HALF = 1,
  parameter int unsigned SKIP_DC     = 1
)
(
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     in_avail,
  input  logic [FFT_AW-1:0]        in_cnt,
  input  logic signed [FFT_DW-1:0] in_re,
  input  logic signed [FFT_DW-1:0] in_im,
  output logic                     mag_valid,
  output logic [FFT_AW-1:0]        mag_addr,
  output logic [FFT_DW-1:0]        mag_data,
  output logic                     done,
  output logic [FFT_AW-1:0]        peak_bin,
  output logic [FFT_DW-1:0]        peak_mag,
  output logic                     seq_err,
  output logic [15:0]              frame_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q,     state_d;
  peak_t             run_q,       run_d;
  logic [FFT_AW-1:0] prev_q,      prev_d;
  logic              seq_err_q,   seq_err_d;
  logic              done_q,      done_d;
  peak_t             peak_q,      peak_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic              w_start;
  logic              w_in_range;
  logic              w_better;
  logic [FFT_AW-1:0] w_next_addr;
  peak_t             w_init;

  fft_mag_approx u_mag (
    .clk         (clk),
    .nrst        (nrst),
    .in_avail_i  (in_avail),
    .in_cnt_i    (in_cnt),
    .in_re_i     (in_re),
    .in_im_i     (in_im),
    .mag_valid_o (mag_valid),
    .mag_addr_o  (mag_addr),
    .mag_data_o  (mag_data)
  );

  // Search-window qualification and running-maximum candidates for stage 3
  always_comb begin
    w_start     = mag_valid && (mag_addr == '0);
    w_in_range  = ((SKIP_DC == 0) || (mag_addr != '0)) &&
                  ((SEARCH_HALF == 0) || (mag_addr < FFT_AW'(FFT_N / 2)));
    w_better    = w_in_range && (mag_data > run_q.mag);
    w_next_addr = prev_q + 1'b1;
    // Frame start: maximum begins at 0/bin 0, then bin 0 itself is evaluated
    w_init.bin  = '0;
    w_init.mag  = (w_in_range && (mag_data > '0)) ? mag_data : '0;
  end

  // Frame FSM: start on index 0, accumulate, report on index 1023
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    prev_d      = prev_q;
    seq_err_d   = seq_err_q;
    done_d      = 1'b0;
    peak_d      = peak_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (w_start) begin
          state_d   = ST_ACC;
          run_d     = w_init;
          prev_d    = '0;
          seq_err_d = 1'b0;
        end
      end
      ST_ACC: begin
        if (w_start) begin
          // Abort the partial frame and restart; not a sequence error
          run_d  = w_init;
          prev_d = '0;
        end else if (mag_valid) begin
          if (mag_addr != w_next_addr) begin
            seq_err_d = 1'b1;
          end
          if (w_better) begin
            run_d.bin = mag_addr;
            run_d.mag = mag_data;
          end
          prev_d = mag_addr;
          if (mag_addr == '1) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            peak_d      = run_d;
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        // An index 0 landing here starts the next frame without an idle gap
        if (w_start) begin
          state_d   = ST_ACC;
          run_d     = w_init;
          prev_d    = '0;
          seq_err_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and result registers; reset discards any frame in progress
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      run_q       <= '0;
      prev_q      <= '0;
      seq_err_q   <= 1'b0;
      done_q      <= 1'b0;
      peak_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      prev_q      <= prev_d;
      seq_err_q   <= seq_err_d;
      done_q      <= done_d;
      peak_q      <= peak_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign done      = done_q;
  assign peak_bin  = peak_q.bin;
  assign peak_mag  = peak_q.mag;
  assign seq_err   = seq_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_peak_detect.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fft_peak_detect
// Description : Directed frames with hand-computed magnitudes; a scoreboard
//               queue is filled by the driver and drained by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_peak_detect;

  logic               clk      = 1'b0;
  logic               nrst     = 1'b1;
  logic               in_avail = 1'b0;
  logic [9:0]         in_cnt   = '0;
  logic signed [31:0] in_re    = '0;
  logic signed [31:0] in_im    = '0;
  logic               mag_valid;
  logic [9:0]         mag_addr;
  logic [31:0]        mag_data;
  logic               done;
  logic [9:0]         peak_bin;
  logic [31:0]        peak_mag;
  logic               seq_err;
  logic [15:0]        frame_cnt;

  fft_peak_detect #(.SEARCH_HALF(1), .SKIP_DC(1)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_avail  (in_avail),
    .in_cnt    (in_cnt),
    .in_re     (in_re),
    .in_im     (in_im),
    .mag_valid (mag_valid),
    .mag_addr  (mag_addr),
    .mag_data  (mag_data),
    .done      (done),
    .peak_bin  (peak_bin),
    .peak_mag  (peak_mag),
    .seq_err   (seq_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] mag;
    int          stamp;
  } exp_t;

  exp_t sbq[$];
  exp_t m_e;
  int   errors     = 0;
  int   checks     = 0;
  int   done_cnt   = 0;
  int   last_stamp = 0;
  int   d0         = 0;

  int                 sp_bin[4];
  logic signed [31:0] sp_re[4];
  logic signed [31:0] sp_im[4];
  logic [31:0]        sp_mag[4];
  int                 n_sp = 0;

  // Monitor: compare every presented magnitude against the scoreboard head
  always @(negedge clk) begin
    if (nrst && done) done_cnt++;
    if (nrst && mag_valid) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL mag_unexpected: got addr=%0d data=%0d, expected no output", mag_addr, mag_data);
      end else begin
        m_e = sbq.pop_front();
        if (mag_addr !== m_e.addr || mag_data !== m_e.mag || cyc != m_e.stamp + 2) begin
          errors++;
          $display("FAIL mag: got addr=%0d data=0x%08h cyc=%0d, expected addr=%0d data=0x%08h cyc=%0d",
                   mag_addr, mag_data, cyc, m_e.addr, m_e.mag, m_e.stamp + 2);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  task automatic send(input int idx, input logic signed [31:0] re,
                      input logic signed [31:0] im, input logic [31:0] exp_mag);
    exp_t e;
    in_avail = 1'b1;
    in_cnt   = idx[9:0];
    in_re    = re;
    in_im    = im;
    e.addr   = idx[9:0];
    e.mag    = exp_mag;
    e.stamp  = cyc + 1;
    last_stamp = cyc + 1;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    in_avail = 1'b0;
  endtask

  task automatic clear_sp();
    n_sp = 0;
  endtask

  task automatic add_sp(input int b, input logic signed [31:0] re,
                        input logic signed [31:0] im, input logic [31:0] m);
    sp_bin[n_sp] = b;
    sp_re[n_sp]  = re;
    sp_im[n_sp]  = im;
    sp_mag[n_sp] = m;
    n_sp++;
  endtask

  // Background bins are (1,1) whose magnitude is 1 + 0 + 0 = 1
  task automatic run_bins(input int lo, input int hi, input int skip);
    logic signed [31:0] re;
    logic signed [31:0] im;
    logic [31:0]        m;
    for (int b = lo; b <= hi; b++) begin
      if (b != skip) begin
        re = 32'sd1;
        im = 32'sd1;
        m  = 32'd1;
        for (int k = 0; k < n_sp; k++) begin
          if (sp_bin[k] == b) begin
            re = sp_re[k];
            im = sp_im[k];
            m  = sp_mag[k];
          end
        end
        send(b, re, im, m);
      end
    end
  endtask

  // Done must appear 3 edges after the edge that sampled the last input
  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_done: got no done pulse, expected one within 12 cycles", name);
    end else begin
      chk({name, "_done_latency"}, cyc, last_stamp + 3);
    end
  endtask

  task automatic drain(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1 nrst = 1'b0;
    #20;
    chk("rst_mag_valid", {31'd0, mag_valid}, 32'd0);
    chk("rst_mag_addr",  {22'd0, mag_addr},  32'd0);
    chk("rst_mag_data",  mag_data,           32'd0);
    chk("rst_done",      {31'd0, done},      32'd0);
    chk("rst_peak_bin",  {22'd0, peak_bin},  32'd0);
    chk("rst_peak_mag",  peak_mag,           32'd0);
    chk("rst_seq_err",   {31'd0, seq_err},   32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    @(posedge clk);
    #1 nrst = 1'b1;

    // Single tone: bin 37 = (1000,-400) -> 1000 + 100 + 50 = 1150
    clear_sp();
    add_sp(37, 32'sd1000, -32'sd400, 32'd1150);
    run_bins(0, 1023, -1);
    wait_done("tone");
    chk("tone_peak_bin",  {22'd0, peak_bin},  32'd37);
    chk("tone_peak_mag",  peak_mag,           32'd1150);
    chk("tone_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    chk("tone_seq_err",   {31'd0, seq_err},   32'd0);
    drain(3);
    chk("tone_sb_empty", sbq.size(), 32'd0);

    // Extremes: 2^31 + 2^29 + 2^28 = 0xB0000000; index 5 in IDLE is not searched
    send(5, 32'sh80000000, 32'sh80000000, 32'hB0000000);
    drain(4);
    chk("ext_sb_empty", sbq.size(), 32'd0);
    chk("ext_peak_bin_hold", {22'd0, peak_bin}, 32'd37);
    chk("ext_peak_mag_hold", peak_mag,          32'd1150);

    // Tie at bins 10 and 20 keeps the lower bin; bin 700 is outside 1..511
    clear_sp();
    add_sp(10,  32'sd500,  32'sd0, 32'd500);
    add_sp(20,  32'sd500,  32'sd0, 32'd500);
    add_sp(700, 32'sd9000, 32'sd0, 32'd9000);
    run_bins(0, 1023, -1);
    wait_done("tie");
    chk("tie_peak_bin",  {22'd0, peak_bin},  32'd10);
    chk("tie_peak_mag",  peak_mag,           32'd500);
    chk("tie_frame_cnt", {16'd0, frame_cnt}, 32'd2);
    drain(3);

    // Restart: partial 0..499 holding a large bin, then a full frame
    d0 = done_cnt;
    clear_sp();
    add_sp(50, 32'sd5000, 32'sd0, 32'd5000);
    run_bins(0, 499, -1);
    clear_sp();
    add_sp(60, 32'sd300, 32'sd0, 32'd300);
    run_bins(0, 1023, -1);
    wait_done("restart");
    chk("restart_peak_bin",  {22'd0, peak_bin},  32'd60);
    chk("restart_peak_mag",  peak_mag,           32'd300);
    chk("restart_seq_err",   {31'd0, seq_err},   32'd0);
    chk("restart_frame_cnt", {16'd0, frame_cnt}, 32'd3);
    drain(4);
    chk("restart_done_count", done_cnt - d0, 32'd1);
    chk("restart_sb_empty", sbq.size(), 32'd0);

    // Gap: index 200 skipped -> sticky seq_err through done
    clear_sp();
    add_sp(100, 32'sd0, 32'sd700, 32'd700);
    run_bins(0, 1023, 200);
    wait_done("gap");
    chk("gap_seq_err",   {31'd0, seq_err},   32'd1);
    chk("gap_peak_bin",  {22'd0, peak_bin},  32'd100);
    chk("gap_frame_cnt", {16'd0, frame_cnt}, 32'd4);
    drain(3);

    // Next frame index 0 clears seq_err once it leaves stage 3
    clear_sp();
    send(0, 32'sd1, 32'sd1, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("gap_seq_err_cleared", {31'd0, seq_err}, 32'd0);

    // Reset mid-frame at index 600
    run_bins(1, 600, -1);
    nrst = 1'b0;
    sbq.delete();
    d0 = done_cnt;
    #2;
    chk("mid_mag_valid", {31'd0, mag_valid}, 32'd0);
    chk("mid_mag_addr",  {22'd0, mag_addr},  32'd0);
    chk("mid_mag_data",  mag_data,           32'd0);
    chk("mid_done",      {31'd0, done},      32'd0);
    chk("mid_peak_bin",  {22'd0, peak_bin},  32'd0);
    chk("mid_peak_mag",  peak_mag,           32'd0);
    chk("mid_seq_err",   {31'd0, seq_err},   32'd0);
    chk("mid_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    chk("mid_no_done", done_cnt - d0, 32'd0);

    clear_sp();
    add_sp(400, 32'sd0, -32'sd2000, 32'd2000);
    run_bins(0, 1023, -1);
    wait_done("post_rst");
    chk("post_rst_peak_bin",  {22'd0, peak_bin},  32'd400);
    chk("post_rst_peak_mag",  peak_mag,           32'd2000);
    chk("post_rst_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    chk("post_rst_seq_err",   {31'd0, seq_err},   32'd0);
    drain(4);
    chk("post_rst_done_count", done_cnt - d0, 32'd1);
    chk("post_rst_sb_empty", sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by 1 ms, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
